// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus and register-file write port between requesters and the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEF_ADDR_W
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              regWrite;
    logic [1:0]        grant;

    modport master (
        output req_valid, req_addr0, req_addr1, req_data0, req_data1,
        input  req_ready, write_reg, write_data, regWrite, grant
    );

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_data0, req_data1,
        output req_ready, write_reg, write_data, regWrite, grant
    );
endinterface

// File: rtl/regfile_wb_arbiter_hold_buf.sv
// One-entry valid/ready holding register; a drain and a refill may share one edge.
module wb_hold_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output logic              in_ready,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    logic              full_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready = !full_q || drain;
    assign full     = full_q;
    assign addr     = addr_q;
    assign data     = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            addr_q <= in_addr;
            data_q <= in_data;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between ALU and load writeback,
// plus a pending-write scoreboard for RAW hazards. WB_FORWARD_EN adds write-port forwarding.
//
// state | meaning
// IDLE  | no grant this cycle, regWrite low
// WRITE | one buffer granted, its write is on the port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 claim_valid,
    input  logic [ADDR_W-1:0]    claim_addr,
    input  logic [ADDR_W-1:0]    chk_addr_a,
    input  logic [ADDR_W-1:0]    chk_addr_b,
    output logic                 hazard
`ifdef WB_FORWARD_EN
    ,
    output logic                 fwd_hit_a,
    output logic                 fwd_hit_b,
    output logic [DATA_W-1:0]    fwd_data_a,
    output logic [DATA_W-1:0]    fwd_data_b
`endif
);
    localparam int NREGS = 2 ** ADDR_W;

    logic [1:0]        buf_full;
    logic [1:0]        buf_ready;
    logic [ADDR_W-1:0] buf_addr [2];
    logic [DATA_W-1:0] buf_data [2];

    wb_state_t         state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              rr_q, rr_d;
    logic [1:0]        eligible;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              sel;

    logic [NREGS-1:0]  pend_q, pend_d;
    logic              hz_a, hz_b;

    wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_alu (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (wb.req_valid[REQ_ALU]),
        .in_addr  (wb.req_addr0),
        .in_data  (wb.req_data0),
        .drain    (grant_q[REQ_ALU]),
        .in_ready (buf_ready[REQ_ALU]),
        .full     (buf_full[REQ_ALU]),
        .addr     (buf_addr[REQ_ALU]),
        .data     (buf_data[REQ_ALU])
    );

    wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_load (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (wb.req_valid[REQ_LOAD]),
        .in_addr  (wb.req_addr1),
        .in_data  (wb.req_data1),
        .drain    (grant_q[REQ_LOAD]),
        .in_ready (buf_ready[REQ_LOAD]),
        .full     (buf_full[REQ_LOAD]),
        .addr     (buf_addr[REQ_LOAD]),
        .data     (buf_data[REQ_LOAD])
    );

    assign wb.req_ready = buf_ready;

    // A buffer being drained this cycle must not be granted again.
    assign eligible = buf_full & ~grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = '0;
        rr_d    = rr_q;
        case (state_q)
            IDLE:    if (|buf_full) state_d = WRITE;
            WRITE:   if (!(|eligible)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (&eligible) begin
            grant_d = rr_q ? 2'b10 : 2'b01;
            rr_d    = ~rr_q;
        end else if (eligible[REQ_ALU]) begin
            grant_d = 2'b01;
            rr_d    = 1'b1;
        end else if (eligible[REQ_LOAD]) begin
            grant_d = 2'b10;
            rr_d    = 1'b0;
        end
    end

    // Register 0 writes still consume a grant but never strobe the register file.
    always_comb begin
        sel       = grant_d[REQ_LOAD];
        wr_en_d   = (|grant_d) && (buf_addr[sel] != '0);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (|grant_d) begin
            wr_addr_d = buf_addr[sel];
            wr_data_d = buf_data[sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pend_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pend_q    <= pend_d;
        end
    end

    assign wb.regWrite   = wr_en_q;
    assign wb.write_reg  = wr_addr_q;
    assign wb.write_data = wr_data_q;
    assign wb.grant      = grant_q;

    // A claim landing with the clearing write wins: the newer producer is still outstanding.
    always_comb begin
        pend_d = pend_q;
        if (wr_en_q) pend_d[wr_addr_q] = 1'b0;
        if (claim_valid && (claim_addr != '0)) pend_d[claim_addr] = 1'b1;
    end

`ifdef WB_FORWARD_EN
    assign fwd_hit_a  = wr_en_q && (chk_addr_a != '0) && (chk_addr_a == wr_addr_q);
    assign fwd_hit_b  = wr_en_q && (chk_addr_b != '0) && (chk_addr_b == wr_addr_q);
    assign fwd_data_a = wr_data_q;
    assign fwd_data_b = wr_data_q;
    assign hz_a = (chk_addr_a != '0) && pend_q[chk_addr_a] && !fwd_hit_a;
    assign hz_b = (chk_addr_b != '0) && pend_q[chk_addr_b] && !fwd_hit_b;
`else
    assign hz_a = (chk_addr_a != '0) && pend_q[chk_addr_a];
    assign hz_b = (chk_addr_b != '0) && pend_q[chk_addr_b];
`endif

    assign hazard = hz_a || hz_b;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (write_reg / write_data / regWrite) between two writeback requesters: requester 0 (ALU) and requester 1 (load unit).
- Each requester has a one-entry holding buffer, and grants are issued by a round-robin state machine.
- A 32-bit pending-write scoreboard lets the issue logic stall on RAW hazards.
- Sits between the execute/memory stages and registerFile.

Parameters:
- DATA_W, 32, data width of write_data and of the requester data inputs.
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester write request valid.
- req_ready  out  2  per-requester ready (holding buffer empty or draining this cycle).
- req_addr0, req_addr1  in  ADDR_W each  destination register per requester.
- req_data0, req_data1  in  DATA_W each  write data per requester.
- claim_valid  in  1  issue stage reserves a destination register.
- claim_addr  in  ADDR_W  register being reserved.
- chk_addr_a, chk_addr_b  in  ADDR_W each  source registers to hazard-check.
- hazard  out  1  chk_addr_a or chk_addr_b is nonzero and pending.
- write_reg  out  ADDR_W  to register file.
- write_data  out  DATA_W  to register file.
- regWrite  out  1  to register file, one-cycle write strobe.
- grant  out  2  one-hot; the requester whose buffer drives the port this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - Both buffers empty; req_ready=2'b11.
  - write_reg=0, write_data=0, regWrite=0, grant=0.
  - Scoreboard all zero; hazard=0.
  - Round-robin pointer rr=0, meaning requester 0 has priority next.
- Accept: on a rising edge with req_valid[i] && req_ready[i], buffer i captures addr/data and becomes full.
  - req_ready[i] = !full[i] || grant[i].
  - A drain and a refill may happen on the same edge, giving full throughput per requester.
- Arbiter FSM, states IDLE and WRITE:
  - IDLE: no buffer full; regWrite=0. Go to WRITE when any buffer is full.
  - WRITE: grant one-hot, registered. If both buffers are full, pick the requester pointed to by rr, then flip rr to the other requester. If only one is full, grant it; rr becomes the non-granted index.
  - Port outputs are registered. write_reg, write_data and regWrite=1 appear on the cycle after the grant decision. Latency from accept to regWrite is 2 cycles when uncontended.
  - Stay in WRITE while any buffer is full after the drain; otherwise return to IDLE.
- Register 0:
  - A request to addr 0 is accepted and drained with regWrite=0 (write suppressed).
  - The write still counts as a grant and still advances rr.
  - The scoreboard never sets bit 0.
- Scoreboard:
  - claim_valid sets pend[claim_addr].
  - The write strobe (regWrite=1) clears pend[write_reg].
  - If a claim and a clear hit the same index on one edge, set wins: the newer producer is still outstanding.
  - hazard is combinational from pend, chk_addr_a and chk_addr_b; address 0 never produces a hazard.
- Reset mid-operation: buffered writes are discarded, no regWrite is issued, and the scoreboard clears.
- Two requests to the same register in flight are written in grant order; ordering between them is the producer's responsibility.

Optional Feature:
- Macro WB_FORWARD_EN.
- When defined, adds outputs fwd_hit_a/fwd_hit_b (1 bit) and fwd_data_a/fwd_data_b (DATA_W), combinational.
  - A hit occurs when a chk address is nonzero and matches write_reg while regWrite=1; fwd_data is write_data.
  - This covers the registerFile delayed-read window.
  - hazard is then suppressed for a source that hits.
- When undefined, these ports are absent and hazard is unchanged.

Decomposition:
- Package regfile_pkg:
  - DATA_W and ADDR_W defaults, NREGS.
  - FSM state enum {IDLE, WRITE}.
  - Requester index constants REQ_ALU=0 and REQ_LOAD=1.
- One natural sub-module: wb_hold_buf, a one-entry valid/ready holding register instantiated twice.
- The arbiter FSM and scoreboard stay in the top module.

Test Plan:
1. Reset with buffers full → all outputs zero within the same cycle as rst_n falling; no regWrite after release.
2. Single write, req0 addr=5 data=32'd10 at cycle 0 → write_reg=5, write_data=10, regWrite=1 at cycle 2, one cycle only.
3. Contention: both requesters valid every cycle, req0 addr=3, req1 addr=4, four cycles → regWrite addresses alternate 3,4,3,4; req_ready deasserts on the ungranted side.
4. Register 0: req1 addr=0 data=32'hFFFF → grant[1] pulses, regWrite stays 0, rr advances.
5. Scoreboard: claim addr=7, chk_addr_a=7 → hazard=1 until the cycle after the write to 7. A simultaneous claim of 7 with that write keeps hazard=1.
6. WB_FORWARD_EN: chk_addr_b=9 while regWrite writes 9 with 32'd42 → fwd_hit_b=1, fwd_data_b=42, hazard=0.
